pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Pipelined control unit for the 5-stage MIPS datapath. Decodes the IF/ID instruction into a control bundle and carries it through ID/EX, EX/MEM and MEM/WB registers. Detects load-use hazards, which stall the front end and insert a bubble, and squashes on a taken branch. It replaces the single-cycle opcode decoder when the datapath is pipelined.

## Interface
Parameters:
- ALUOP_W, default 8: ALU op width; the value is the opcode zero-extended (R-type = 0).
- REG_AW, default 5: register address width.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- instr_i  in  32  instruction currently in IF/ID.
- instr_valid_i  in  1  instr_i holds a real instruction.
- ex_br_taken_i  in  1  branch in EX resolved taken in this cycle.
- stall_o  out  1  combinational; hold PC and IF/ID this cycle.
- flush_o  out  1  combinational; clear IF/ID this cycle (equals ex_br_taken_i).
- ex_valid_o, ex_alu_op_o[ALUOP_W], ex_alusrc_o, ex_regdst_o, ex_branch_o  out  EX-stage controls.
- ex_rs_o, ex_rt_o  out  REG_AW each  source register numbers in EX, for the forwarding unit.
- mem_valid_o, mem_memread_o, mem_memwrite_o  out  MEM-stage controls.
- wb_valid_o, wb_regwrite_o, wb_memtoreg_o  out  1 each  WB-stage controls.
- wb_wraddr_o  out  REG_AW  WB destination register.
- illegal_o  out  1  registered one-cycle pulse, aligned with EX, for an undecodable opcode.

## Operation
Decode table (opcode → controls):
- 0x00 R-type: RegWrite, RegDst.
- 0x08 addi: ALUSrc, RegWrite.
- 0x0A slti: ALUSrc, RegWrite.
- 0x23 lw: ALUSrc, RegWrite, MemRead, MemtoReg.
- 0x2B sw: ALUSrc, MemWrite.
- 0x04 beq: Branch.
- Any other opcode, or instr_valid_i=0: all controls 0 (bubble). An invalid opcode with instr_valid_i=1 also sets illegal_o next cycle.

Write address:
- rd (instr[15:11]) when RegDst; otherwise rt (instr[20:16]).
- rs = instr[25:21].

Source usage:
- rs is used by all decoded opcodes.
- rt is used only by R-type, sw, beq (and bne when enabled).

Load-use hazard:
- stall_o=1 when ex_valid_o & ex_memread (registered lw in EX) & ex write address ≠ 0 & it equals a used source (rs or rt) of a valid instr_i.

Pipeline advance each edge:
- EX gets the decoded bundle, or a bubble if stall_o or ex_br_taken_i.
- MEM gets EX; WB gets MEM. MEM and WB always advance and never stall.

Priorities and boundary cases:
- Flush has priority over stall: stall_o is forced to 0 when ex_br_taken_i=1.
- Register 0 as destination never causes a stall.
- Back-to-back lw→use stalls exactly one cycle; the next cycle the lw is in MEM and the stall clears.
- A lw in EX with a taken branch in the same cycle is impossible (single EX slot). No special case is required.

## Timing
- Reset (rst_i low, asynchronously): all valid, control, address and illegal_o outputs = 0 immediately. stall_o and flush_o then follow the combinational equations with EX empty, so stall_o=0.
- Latency: an instruction decoded in cycle n appears on ex_* at n+1, mem_* at n+2, wb_* at n+3.
- Reset deasserted mid-stream: the pipeline restarts empty. No partial bundle survives.
- stall_o and flush_o are valid in the same cycle as their inputs, with no register.

## Configuration
- PIPE_CTRL_BNE_EN defined:
  - opcode 0x05 (bne) decodes as Branch with an added ex_bne_o output (1 for bne, 0 for beq).
  - bne uses rt for hazard detection.
- Undefined: 0x05 is illegal (bubble plus illegal_o), and ex_bne_o does not exist.

## Structure
- Package pipe_ctrl_pkg holds:
  - opcode localparams (OP_RTYPE, OP_ADDI, OP_SLTI, OP_LW, OP_SW, OP_BEQ, OP_BNE);
  - packed struct ctrl_t for the EX/MEM/WB bundle;
  - the constant CTRL_BUBBLE.
- Sub-module pipe_ctrl_dec: purely combinational opcode→ctrl_t decode plus a source-usage flag. The top level holds the stage registers and hazard logic.

## Test plan
- Reset mid-run: assert rst_i between edges → all outputs 0 immediately; first instruction after release appears on ex_* one cycle later.
- Stream addi, sw, beq → ex_alu_op_o = 0x08, 0x2B, 0x04 on consecutive cycles; sw shows mem_memwrite_o=1 at n+2; addi shows wb_regwrite_o=1 with wb_wraddr_o=rt at n+3.
- Stall: lw $8,0($1) then add $9,$8,$2 → stall_o=1 for exactly one cycle, EX bubble (ex_valid_o=0); add enters EX the following cycle.
- No stall on $0: lw $0 then add $9,$0,$2 → stall_o stays 0.
- Flush priority: ex_br_taken_i=1 in the same cycle as a load-use condition → stall_o=0, flush_o=1, next EX is a bubble.
- Illegal: opcode 0x3F valid → bubble through all stages, illegal_o=1 for exactly one cycle at n+1. Opcode 0x05 behaves as bne only with PIPE_CTRL_BNE_EN defined.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared opcodes and control-bundle types for the pipelined MIPS control unit.
// Optional PIPE_CTRL_BNE_EN adds the bne flag to the EX part of the bundle.
package pipe_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;

    typedef struct packed {
        logic [5:0] aluOp;
        logic       aluSrc;
        logic       regDst;
        logic       branch;
`ifdef PIPE_CTRL_BNE_EN
        logic       bne;
`endif
    } exCtrl_t;

    typedef struct packed {
        logic memRead;
        logic memWrite;
    } memCtrl_t;

    typedef struct packed {
        logic regWrite;
        logic memToReg;
    } wbCtrl_t;

    // Each stage drops the sub-bundle it consumes, so MEM and WB carry only what follows them.
    typedef struct packed {
        logic     valid;
        exCtrl_t  ex;
        memCtrl_t mem;
        wbCtrl_t  wb;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/pipe_ctrl_dec.sv
// Combinational opcode decode into the pipeline control bundle, plus rt-usage and illegal flags.
// With PIPE_CTRL_BNE_EN defined, opcode 0x05 decodes as bne; otherwise it is illegal.
module pipe_ctrl_dec
    import pipe_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic       instrValid,
    output ctrl_t      ctrl,
    output logic       usesRt,
    output logic       illegal
);

    always_comb begin
        // NOTE: every output gets its default first, so no path through the case can infer a latch.
        ctrl    = CTRL_BUBBLE;
        usesRt  = 1'b0;
        illegal = 1'b0;
        if (instrValid) begin
            ctrl.valid    = 1'b1;
            ctrl.ex.aluOp = opcode;
            case (opcode)
                OP_RTYPE: begin
                    ctrl.ex.regDst   = 1'b1;
                    ctrl.wb.regWrite = 1'b1;
                    usesRt           = 1'b1;
                end
                OP_ADDI, OP_SLTI: begin
                    ctrl.ex.aluSrc   = 1'b1;
                    ctrl.wb.regWrite = 1'b1;
                end
                OP_LW: begin
                    ctrl.ex.aluSrc   = 1'b1;
                    ctrl.wb.regWrite = 1'b1;
                    ctrl.mem.memRead = 1'b1;
                    ctrl.wb.memToReg = 1'b1;
                end
                OP_SW: begin
                    ctrl.ex.aluSrc    = 1'b1;
                    ctrl.mem.memWrite = 1'b1;
                    usesRt            = 1'b1;
                end
                OP_BEQ: begin
                    ctrl.ex.branch = 1'b1;
                    usesRt         = 1'b1;
                end
`ifdef PIPE_CTRL_BNE_EN
                OP_BNE: begin
                    ctrl.ex.branch = 1'b1;
                    ctrl.ex.bne    = 1'b1;
                    usesRt         = 1'b1;
                end
`endif
                default: begin
                    ctrl    = CTRL_BUBBLE;
                    illegal = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipelined control unit: decodes IF/ID, carries controls through EX/MEM/WB, stalls on load-use, squashes on taken branch.
// Optional PIPE_CTRL_BNE_EN adds bne decode and the ex_bne_o output.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int ALUOP_W = 8,
    parameter int REG_AW  = 5
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [31:0]        instr_i,
    input  logic               instr_valid_i,
    input  logic               ex_br_taken_i,
    output logic               stall_o,
    output logic               flush_o,
    output logic               ex_valid_o,
    output logic [ALUOP_W-1:0] ex_alu_op_o,
    output logic               ex_alusrc_o,
    output logic               ex_regdst_o,
    output logic               ex_branch_o,
`ifdef PIPE_CTRL_BNE_EN
    output logic               ex_bne_o,
`endif
    output logic [REG_AW-1:0]  ex_rs_o,
    output logic [REG_AW-1:0]  ex_rt_o,
    output logic               mem_valid_o,
    output logic               mem_memread_o,
    output logic               mem_memwrite_o,
    output logic               wb_valid_o,
    output logic               wb_regwrite_o,
    output logic               wb_memtoreg_o,
    output logic [REG_AW-1:0]  wb_wraddr_o,
    output logic               illegal_o
);

    ctrl_t             decCtrl;
    logic              decUsesRt;
    logic              decIllegal;
    logic [REG_AW-1:0] decRs;
    logic [REG_AW-1:0] decRt;
    logic [REG_AW-1:0] decWrAddr;
    logic              unusedInstr;

    ctrl_t             exQ;
    logic [REG_AW-1:0] exRs;
    logic [REG_AW-1:0] exRt;
    logic [REG_AW-1:0] exWrAddr;
    logic              exIllegal;

    logic              memValid;
    memCtrl_t          memQ;
    wbCtrl_t           memWb;
    logic [REG_AW-1:0] memWrAddr;

    logic              wbValid;
    wbCtrl_t           wbQ;
    logic [REG_AW-1:0] wbWrAddr;

    logic              loadInEx;
    logic              useHit;
    logic              squash;

    pipe_ctrl_dec uDec (
        .opcode     (instr_i[31:26]),
        .instrValid (instr_valid_i),
        .ctrl       (decCtrl),
        .usesRt     (decUsesRt),
        .illegal    (decIllegal)
    );

    assign decRs       = REG_AW'(instr_i[25:21]);
    assign decRt       = REG_AW'(instr_i[20:16]);
    assign decWrAddr   = decCtrl.ex.regDst ? REG_AW'(instr_i[15:11]) : decRt;
    assign unusedInstr = ^instr_i[10:0];

    // Every decoded opcode reads rs, so a valid bundle implies rs is a live source.
    assign loadInEx = exQ.valid && exQ.mem.memRead && (exWrAddr != '0);
    assign useHit   = decCtrl.valid && ((decRs == exWrAddr) || (decUsesRt && (decRt == exWrAddr)));
    assign flush_o  = ex_br_taken_i;
    assign stall_o  = loadInEx && useHit && !ex_br_taken_i;
    assign squash   = stall_o || ex_br_taken_i;

    // NOTE: asynchronous reset clears every stage register, so nothing of a partial bundle survives.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            exQ       <= CTRL_BUBBLE;
            exRs      <= '0;
            exRt      <= '0;
            exWrAddr  <= '0;
            exIllegal <= 1'b0;
            memValid  <= 1'b0;
            memQ      <= '0;
            memWb     <= '0;
            memWrAddr <= '0;
            wbValid   <= 1'b0;
            wbQ       <= '0;
            wbWrAddr  <= '0;
        end else begin
            // A squashed wrong-path instruction must not raise illegal_o either.
            if (squash) begin
                exQ       <= CTRL_BUBBLE;
                exRs      <= '0;
                exRt      <= '0;
                exWrAddr  <= '0;
                exIllegal <= 1'b0;
            end else begin
                exQ       <= decCtrl;
                exRs      <= decCtrl.valid ? decRs : '0;
                exRt      <= decCtrl.valid ? decRt : '0;
                exWrAddr  <= decCtrl.valid ? decWrAddr : '0;
                exIllegal <= decIllegal;
            end
            memValid  <= exQ.valid;
            memQ      <= exQ.mem;
            memWb     <= exQ.wb;
            memWrAddr <= exWrAddr;
            wbValid   <= memValid;
            wbQ       <= memWb;
            wbWrAddr  <= memWrAddr;
        end
    end

    assign ex_valid_o     = exQ.valid;
    assign ex_alu_op_o    = ALUOP_W'(exQ.ex.aluOp);
    assign ex_alusrc_o    = exQ.ex.aluSrc;
    assign ex_regdst_o    = exQ.ex.regDst;
    assign ex_branch_o    = exQ.ex.branch;
`ifdef PIPE_CTRL_BNE_EN
    assign ex_bne_o       = exQ.ex.bne;
`endif
    assign ex_rs_o        = exRs;
    assign ex_rt_o        = exRt;
    assign illegal_o      = exIllegal;
    assign mem_valid_o    = memValid;
    assign mem_memread_o  = memQ.memRead;
    assign mem_memwrite_o = memQ.memWrite;
    assign wb_valid_o     = wbValid;
    assign wb_regwrite_o  = wbQ.regWrite;
    assign wb_memtoreg_o  = wbQ.memToReg;
    assign wb_wraddr_o    = wbWrAddr;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Testbench for pipe_ctrl: directed vector table, mid-run reset sequence, and random stream
// checked against a history-queue reference model built from the decode table.
`timescale 1ns/1ps
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rstN;
    logic [31:0] instr;
    logic        instrValid;
    logic        brTaken;
    logic        stall, flush;
    logic        exValid, exAluSrc, exRegDst, exBranch;
    logic [7:0]  exAluOp;
    logic [4:0]  exRs, exRt, wbWrAddr;
    logic        memValid, memRead, memWrite;
    logic        wbValid, wbRegWrite, wbMemToReg;
    logic        illegal;
`ifdef PIPE_CTRL_BNE_EN
    logic        exBne;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_ctrl dut (
        .clk_i          (clk),
        .rst_i          (rstN),
        .instr_i        (instr),
        .instr_valid_i  (instrValid),
        .ex_br_taken_i  (brTaken),
        .stall_o        (stall),
        .flush_o        (flush),
        .ex_valid_o     (exValid),
        .ex_alu_op_o    (exAluOp),
        .ex_alusrc_o    (exAluSrc),
        .ex_regdst_o    (exRegDst),
        .ex_branch_o    (exBranch),
`ifdef PIPE_CTRL_BNE_EN
        .ex_bne_o       (exBne),
`endif
        .ex_rs_o        (exRs),
        .ex_rt_o        (exRt),
        .mem_valid_o    (memValid),
        .mem_memread_o  (memRead),
        .mem_memwrite_o (memWrite),
        .wb_valid_o     (wbValid),
        .wb_regwrite_o  (wbRegWrite),
        .wb_memtoreg_o  (wbMemToReg),
        .wb_wraddr_o    (wbWrAddr),
        .illegal_o      (illegal)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic       valid, aluSrc, regDst, branch, bne;
        logic       memRead, memWrite, regWrite, memToReg;
        logic       usesRt, illegal;
        logic [7:0] aluOp;
        logic [4:0] rs, rt, wr;
    } rec_t;

    function automatic rec_t decodeRef(input logic [31:0] ins, input logic v);
        rec_t r;
        logic [5:0] op;
        r  = '0;
        op = ins[31:26];
        if (!v) return r;
        r.valid = 1'b1;
        case (op)
            6'h00: begin r.regWrite = 1; r.regDst = 1; r.usesRt = 1; end
            6'h08, 6'h0A: begin r.aluSrc = 1; r.regWrite = 1; end
            6'h23: begin r.aluSrc = 1; r.regWrite = 1; r.memRead = 1; r.memToReg = 1; end
            6'h2B: begin r.aluSrc = 1; r.memWrite = 1; r.usesRt = 1; end
            6'h04: begin r.branch = 1; r.usesRt = 1; end
`ifdef PIPE_CTRL_BNE_EN
            6'h05: begin r.branch = 1; r.bne = 1; r.usesRt = 1; end
`endif
            default: begin
                r = '0;
                r.illegal = 1'b1;
                return r;
            end
        endcase
        r.aluOp = {2'b00, op};
        r.rs    = ins[25:21];
        r.rt    = ins[20:16];
        r.wr    = r.regDst ? ins[15:11] : ins[20:16];
        return r;
    endfunction

    // hist[0] is what sits in EX, hist[1] in MEM, hist[2] in WB.
    rec_t hist[$];

    task automatic resetModel();
        hist = {};
        repeat (3) hist.push_front('0);
    endtask

    task automatic cycleModel(input logic [31:0] ins, input logic v, input logic br, output logic stalled);
        rec_t d, ex, mem, wb;
        logic expStall;
        instr = ins; instrValid = v; brTaken = br;
        #2;
        d = decodeRef(ins, v);
        ex = hist[0]; mem = hist[1]; wb = hist[2];
        expStall = !br && ex.valid && ex.memRead && (ex.wr != 0) && d.valid &&
                   ((d.rs == ex.wr) || (d.usesRt && (d.rt == ex.wr)));
        check("stall", stall, expStall);
        check("flush", flush, br);
        check("exValid", exValid, ex.valid);
        check("exAluOp", exAluOp, ex.aluOp);
        check("exAluSrc", exAluSrc, ex.aluSrc);
        check("exRegDst", exRegDst, ex.regDst);
        check("exBranch", exBranch, ex.branch);
`ifdef PIPE_CTRL_BNE_EN
        check("exBne", exBne, ex.bne);
`endif
        check("exRs", exRs, ex.rs);
        check("exRt", exRt, ex.rt);
        check("illegal", illegal, ex.illegal);
        check("memValid", memValid, mem.valid);
        check("memRead", memRead, mem.memRead);
        check("memWrite", memWrite, mem.memWrite);
        check("wbValid", wbValid, wb.valid);
        check("wbRegWrite", wbRegWrite, wb.regWrite);
        check("wbMemToReg", wbMemToReg, wb.memToReg);
        check("wbWrAddr", wbWrAddr, wb.wr);
        @(posedge clk); #1;
        if (expStall || br) hist.push_front('0);
        else                hist.push_front(d);
        void'(hist.pop_back());
        stalled = expStall;
    endtask

    // ---------------- directed vector table ----------------
    localparam logic [31:0] I_ADDI  = {6'h08, 5'd1, 5'd5, 16'h0004};
    localparam logic [31:0] I_SW    = {6'h2B, 5'd2, 5'd6, 16'h0000};
    localparam logic [31:0] I_BEQ   = {6'h04, 5'd3, 5'd4, 16'h0000};
    localparam logic [31:0] I_LW8   = {6'h23, 5'd1, 5'd8, 16'h0000};
    localparam logic [31:0] I_ADD98 = {6'h00, 5'd8, 5'd2, 5'd9, 5'd0, 6'h20};
    localparam logic [31:0] I_LW0   = {6'h23, 5'd1, 5'd0, 16'h0000};
    localparam logic [31:0] I_ADD90 = {6'h00, 5'd0, 5'd2, 5'd9, 5'd0, 6'h20};
    localparam logic [31:0] I_ILL   = {6'h3F, 26'h0};

    typedef struct packed {
        logic [31:0] ins;
        logic        v, br;
        logic        stall, flush, exValid;
        logic [7:0]  exAluOp;
        logic        memWrite, wbRegWrite;
        logic [4:0]  wbWr;
        logic        illegal;
    } vec_t;

    function automatic vec_t mkVec(input logic [31:0] ins, input logic v, input logic br,
                                   input logic st, input logic fl, input logic exv,
                                   input logic [7:0] op, input logic mw, input logic rw,
                                   input logic [4:0] wr, input logic il);
        vec_t r;
        r.ins = ins; r.v = v; r.br = br; r.stall = st; r.flush = fl; r.exValid = exv;
        r.exAluOp = op; r.memWrite = mw; r.wbRegWrite = rw; r.wbWr = wr; r.illegal = il;
        return r;
    endfunction

    vec_t vecs[14];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic        stalled;
        logic [31:0] cur;
        logic        curV;
        logic [5:0]  op;

        //           ins      v  br  st fl exv op     mw rw wr  il
        vecs[0]  = mkVec(I_ADDI,  1, 0, 0, 0, 0, 8'h00, 0, 0, 5'd0, 0);
        vecs[1]  = mkVec(I_SW,    1, 0, 0, 0, 1, 8'h08, 0, 0, 5'd0, 0);
        vecs[2]  = mkVec(I_BEQ,   1, 0, 0, 0, 1, 8'h2B, 0, 0, 5'd0, 0);
        vecs[3]  = mkVec(I_LW8,   1, 0, 0, 0, 1, 8'h04, 1, 1, 5'd5, 0);
        vecs[4]  = mkVec(I_ADD98, 1, 0, 1, 0, 1, 8'h23, 0, 0, 5'd6, 0);
        vecs[5]  = mkVec(I_ADD98, 1, 0, 0, 0, 0, 8'h00, 0, 0, 5'd4, 0);
        vecs[6]  = mkVec(I_LW0,   1, 0, 0, 0, 1, 8'h00, 0, 1, 5'd8, 0);
        vecs[7]  = mkVec(I_ADD90, 1, 0, 0, 0, 1, 8'h23, 0, 0, 5'd0, 0);
        vecs[8]  = mkVec(I_LW8,   1, 0, 0, 0, 1, 8'h00, 0, 1, 5'd9, 0);
        vecs[9]  = mkVec(I_ADD98, 1, 1, 0, 1, 1, 8'h23, 0, 1, 5'd0, 0);
        vecs[10] = mkVec(32'h0,   0, 0, 0, 0, 0, 8'h00, 0, 1, 5'd9, 0);
        vecs[11] = mkVec(I_ILL,   1, 0, 0, 0, 0, 8'h00, 0, 1, 5'd8, 0);
        vecs[12] = mkVec(32'h0,   0, 0, 0, 0, 0, 8'h00, 0, 0, 5'd0, 1);
        vecs[13] = mkVec(32'h0,   0, 0, 0, 0, 0, 8'h00, 0, 0, 5'd0, 0);

        rstN = 1'b0; instr = '0; instrValid = 1'b0; brTaken = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset exValid", exValid, 0);
        check("reset memValid", memValid, 0);
        check("reset wbValid", wbValid, 0);
        check("reset stall", stall, 0);
        #1 rstN = 1'b1;

        for (int i = 0; i < 14; i++) begin
            instr = vecs[i].ins; instrValid = vecs[i].v; brTaken = vecs[i].br;
            #2;
            check($sformatf("row%0d stall", i), stall, vecs[i].stall);
            check($sformatf("row%0d flush", i), flush, vecs[i].flush);
            check($sformatf("row%0d exValid", i), exValid, vecs[i].exValid);
            check($sformatf("row%0d exAluOp", i), exAluOp, vecs[i].exAluOp);
            check($sformatf("row%0d memWrite", i), memWrite, vecs[i].memWrite);
            check($sformatf("row%0d wbRegWrite", i), wbRegWrite, vecs[i].wbRegWrite);
            check($sformatf("row%0d wbWrAddr", i), wbWrAddr, vecs[i].wbWr);
            check($sformatf("row%0d illegal", i), illegal, vecs[i].illegal);
            @(posedge clk); #1;
        end

        // Mid-run reset with a live load-use hazard pending.
        instr = I_LW8; instrValid = 1'b1; brTaken = 1'b0;
        @(posedge clk); #1;
        instr = I_ADD98;
        #1;
        check("pre-reset stall", stall, 1);
        #1 rstN = 1'b0;
        #1;
        check("midrst exValid", exValid, 0);
        check("midrst exAluOp", exAluOp, 0);
        check("midrst exRs", exRs, 0);
        check("midrst exRt", exRt, 0);
        check("midrst memValid", memValid, 0);
        check("midrst memRead", memRead, 0);
        check("midrst wbValid", wbValid, 0);
        check("midrst wbRegWrite", wbRegWrite, 0);
        check("midrst wbWrAddr", wbWrAddr, 0);
        check("midrst illegal", illegal, 0);
        check("midrst stall", stall, 0);
        @(posedge clk); #1;
        check("held rst exValid", exValid, 0);
        #1 rstN = 1'b1;
        resetModel();
        cycleModel(I_ADDI, 1'b1, 1'b0, stalled);
        #1;
        check("post-rst exValid", exValid, 1);
        check("post-rst exAluOp", exAluOp, 8'h08);
        #1;

        // Randomized stream against the model; IF/ID is held while stalled.
        stalled = 1'b0;
        cur = '0; curV = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!stalled) begin
                case ($urandom_range(0, 8))
                    0: op = 6'h00;
                    1: op = 6'h08;
                    2: op = 6'h0A;
                    3: op = 6'h23;
                    4: op = 6'h2B;
                    5: op = 6'h04;
                    6: op = 6'h05;
                    7: op = 6'h3F;
                    default: op = 6'($urandom_range(0, 63));
                endcase
                cur = {op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                       5'($urandom_range(0, 3)), 11'($urandom)};
                curV = ($urandom_range(0, 9) != 0);
            end
            cycleModel(cur, curV, ($urandom_range(0, 9) == 0), stalled);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
